stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameters SHALL be: W, default 16, data/address width; STACK_TOP, default 16'h0200, SP value meaning empty; STACK_BOTTOM, default 16'h0100, SP value meaning full; BYTES = W/8 (derived, not overridable).
REQ-002 Ports SHALL be, clock and reset first: clk  in  1  sole clock; rst  in  1  asynchronous active-low reset.
REQ-003 req_valid  in  1  request present; req_op  in  2  operation; req_data  in  W  push data or load value; req_ready  out  1  controller can accept.
REQ-004 rsp_valid  out  1  result present; rsp_ready  in  1  consumer accepts; rsp_data  out  W  pop data, else 0; rsp_err  out  1  request rejected.
REQ-005 mem_req  out  1  memory access; mem_we  out  1  write strobe; mem_addr  out  W  byte address; mem_wdata  out  W  write data; mem_rdata  in  W  read data; mem_ack  in  1  access complete.
REQ-006 sp_ld/sp_inc/sp_dec  out  1 each  stack-pointer strobes; sp_d  out  W  load value; sp_q  in  W  current stack-pointer value.

Function
REQ-007 req_op encoding SHALL be 2'b00 PUSH, 2'b01 POP, 2'b10 LOAD, 2'b11 reserved (rejected with rsp_err=1).
REQ-008 FSM states SHALL be IDLE, DEC, WR, RD, INC, LDS, RESP; req_ready=1 only in IDLE; op and req_data are registered on accept (req_valid & req_ready).
REQ-009 Stack SHALL grow downward by BYTES: PUSH pre-decrements then writes; POP reads then post-increments.
REQ-010 PUSH: accept at T; T+1 DEC with sp_dec=1 for exactly one cycle; from T+2 WR with mem_req=1, mem_we=1, mem_addr=sp_q, mem_wdata=captured data, held until mem_ack; cycle after ack RESP.
REQ-011 POP: accept at T; from T+1 RD with mem_req=1, mem_we=0, mem_addr=sp_q until mem_ack; mem_rdata captured on ack; next cycle INC with sp_inc=1 for one cycle; then RESP with rsp_data=captured value.
REQ-012 LOAD: accept at T; T+1 LDS with sp_ld=1, sp_d=captured data for one cycle; then RESP.
REQ-013 Overflow: PUSH accepted with sp_q==STACK_BOTTOM SHALL go directly to RESP with rsp_err=1; no strobe, no memory access.
REQ-014 Underflow: POP accepted with sp_q==STACK_TOP SHALL go directly to RESP with rsp_err=1; no strobe, no memory access.
REQ-015 LOAD value outside [STACK_BOTTOM, STACK_TOP] or not a multiple of BYTES SHALL go to RESP with rsp_err=1 and no sp_ld.
REQ-016 RESP: rsp_valid=1 with rsp_data/rsp_err stable until rsp_ready; transfer cycle returns to IDLE; new request accepted the following cycle at the earliest.
REQ-017 Zero-latency ack: mem_ack high in the first WR/RD cycle SHALL complete the access in that cycle.
REQ-018 At most one of sp_ld, sp_inc, sp_dec SHALL be high in any cycle; all outputs SHALL be registered or decoded from state only (no req_* to mem_* combinational path).
REQ-019 mem_ack outside WR/RD SHALL be ignored.

Reset
REQ-020 rst low SHALL asynchronously force IDLE; req_ready=1 after release; rsp_valid, rsp_err, mem_req, mem_we, sp_ld, sp_inc, sp_dec = 0; rsp_data, mem_addr, mem_wdata, sp_d = 0.
REQ-021 Reset mid-operation SHALL abort silently: mem_req drops immediately, no response is produced, no further strobes issue.

Structure
REQ-022 Op encodings and FSM state encoding SHALL live in shared package minx16_stack_pkg.
REQ-023 No sub-module; the stack-pointer register is instantiated beside this block in the parent, with its strobes wired from sp_ld/sp_inc/sp_dec/sp_d and its Q to sp_q.

Verification
REQ-024 LOAD 16'h0200 -> sp_ld pulse one cycle after accept, sp_d=16'h0200, rsp_valid with rsp_err=0.
REQ-025 With SP=16'h0200, PUSH 16'hBEEF, mem_ack 3 cycles late -> sp_dec pulse, write to 16'h01FE data 16'hBEEF, SP=16'h01FE, rsp_err=0.
REQ-026 Then POP with zero-latency ack returning 16'hBEEF -> read at 16'h01FE, sp_inc pulse, rsp_data=16'hBEEF, SP=16'h0200.
REQ-027 POP at SP=16'h0200 -> rsp_err=1, no mem_req, no strobe; PUSH at SP=16'h0100 -> rsp_err=1, no mem_req, no strobe; LOAD 16'h0201 -> rsp_err=1, no sp_ld.
REQ-028 rst low during WR with mem_ack withheld -> mem_req=0 immediately, no rsp_valid, req_ready=1 after release.
REQ-029 rsp_ready held low 5 cycles during RESP -> rsp_valid/rsp_data stable, req_ready=0 throughout.

Source files
------------

// File: rtl/minx16_stack_pkg.sv
// Shared encodings for the minx16 hardware stack controller.
// Operation codes and FSM states used by stack_ctrl and its environment.
package minx16_stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_LOAD = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_INC  = 3'd4,
    ST_LDS  = 3'd5,
    ST_RESP = 3'd6
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Hardware stack controller: sequences SP strobes and memory accesses.
// Stack grows downward; the SP register itself lives in the parent.
import minx16_stack_pkg::*;

module stack_ctrl #(
  parameter int           W            = 16,
  parameter logic [W-1:0] STACK_TOP    = 16'h0200,
  parameter logic [W-1:0] STACK_BOTTOM = 16'h0100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_data,
  output logic         req_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         sp_ld,
  output logic         sp_inc,
  output logic         sp_dec,
  output logic [W-1:0] sp_d,
  input  logic [W-1:0] sp_q
);

  localparam int BYTES = W / 8;

  state_e       r_state;
  state_e       w_next;
  op_e          r_op;
  logic [W-1:0] r_data;
  logic [W-1:0] r_rdata;
  logic         r_err;
  logic         w_err;
  logic         w_accept;
  logic         w_ld_ok;
  op_e          w_op;

  assign w_op     = op_e'(req_op);
  assign w_accept = req_valid & (r_state == ST_IDLE);
  assign w_ld_ok  = (req_data >= STACK_BOTTOM) &&
                    (req_data <= STACK_TOP) &&
                    ((req_data & W'(BYTES - 1)) == '0);

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (w_op)
            OP_PUSH: begin
              w_err  = (sp_q == STACK_BOTTOM);
              w_next = w_err ? ST_RESP : ST_DEC;
            end
            OP_POP: begin
              w_err  = (sp_q == STACK_TOP);
              w_next = w_err ? ST_RESP : ST_RD;
            end
            OP_LOAD: begin
              w_err  = ~w_ld_ok;
              w_next = w_err ? ST_RESP : ST_LDS;
            end
            default: begin
              w_err  = 1'b1;
              w_next = ST_RESP;
            end
          endcase
        end
      end
      ST_DEC:  w_next = ST_WR;
      ST_WR:   if (mem_ack) w_next = ST_RESP;
      ST_RD:   if (mem_ack) w_next = ST_INC;
      ST_INC:  w_next = ST_RESP;
      ST_LDS:  w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_PUSH;
      r_data  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= w_op;
        r_data <= req_data;
        r_err  <= w_err;
      end
      if (r_state == ST_RD && mem_ack) r_rdata <= mem_rdata;
    end
  end

  // Everything below decodes from registered state; no req_* -> mem_* path.
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_data  = (rsp_valid && r_op == OP_POP && !r_err) ? r_rdata : '0;
  assign mem_req   = (r_state == ST_WR) | (r_state == ST_RD);
  assign mem_we    = (r_state == ST_WR);
  assign mem_addr  = mem_req ? sp_q : '0;
  assign mem_wdata = mem_we ? r_data : '0;
  assign sp_dec    = (r_state == ST_DEC);
  assign sp_inc    = (r_state == ST_INC);
  assign sp_ld     = (r_state == ST_LDS);
  assign sp_d      = sp_ld ? r_data : '0;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with an SP register and memory model.
// Expected responses are queued on request and compared on response.
module tb_stack_ctrl;
  import minx16_stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_data = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        sp_ld;
  logic        sp_inc;
  logic        sp_dec;
  logic [15:0] sp_d;
  logic [15:0] sp_q;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .sp_ld(sp_ld), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .sp_d(sp_d), .sp_q(sp_q)
  );

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Parent-side stack pointer register
  logic [15:0] sp;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sp <= 16'h0200;
    else if (sp_ld) sp <= sp_d;
    else if (sp_inc) sp <= sp + 16'd2;
    else if (sp_dec) sp <= sp - 16'd2;
  end
  assign sp_q = sp;

  // Memory with programmable ack latency
  int          ack_delay = 0;
  int          mcnt = 0;
  logic [15:0] mem [logic [15:0]];
  always @(negedge clk) begin
    if (mem_req === 1'b1 && !mem_ack) begin
      if (mcnt >= ack_delay) begin
        mem_ack = 1'b1;
        mcnt = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
      end else begin
        mcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      mcnt = 0;
    end
  end

  int n_dec = 0, n_inc = 0, n_ld = 0, n_mreq = 0, n_multi = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (sp_dec === 1'b1) n_dec++;
      if (sp_inc === 1'b1) n_inc++;
      if (sp_ld === 1'b1) n_ld++;
      if (mem_req === 1'b1) n_mreq++;
      if (int'(sp_dec) + int'(sp_inc) + int'(sp_ld) > 1) n_multi++;
    end
  end

  function automatic int activity();
    return n_dec + n_inc + n_ld + n_mreq;
  endfunction

  task automatic send(input logic [1:0] op, input logic [15:0] d,
                      input logic [15:0] ed, input logic ee,
                      input bit expect_rsp);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    if (expect_rsp) sb.push_back('{ed, ee});
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = '0;
  endtask

  task automatic get_rsp(input int budget);
    int   n = 0;
    exp_t e;
    while (rsp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      failures++;
      $display("FAIL rsp_unexpected data=%h err=%b", rsp_data, rsp_err);
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        failures++;
        $display("FAIL rsp data=%h err=%b required data=%h err=%b",
                 rsp_data, rsp_err, e.data, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, mem_req, mem_we, sp_ld, sp_inc, sp_dec}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl got %b required 0",
               {rsp_valid, rsp_err, mem_req, mem_we, sp_ld, sp_inc, sp_dec});
    end
    checks++;
    if ({rsp_data, mem_addr, mem_wdata, sp_d} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got %h required 0",
               {rsp_data, mem_addr, mem_wdata, sp_d});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b valid=%b required 1 0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_load();
    logic [15:0] vals [2];
    vals[0] = 16'h0180;
    vals[1] = 16'h0200;
    foreach (vals[i]) begin
      send(OP_LOAD, vals[i], 16'h0000, 1'b0, 1'b1);
      checks++;
      if (sp_ld !== 1'b1 || sp_d !== vals[i] || sp_inc || sp_dec) begin
        failures++;
        $display("FAIL load_strobe ld=%b d=%h required 1 %h",
                 sp_ld, sp_d, vals[i]);
      end
      get_rsp(10);
      checks++;
      if (sp !== vals[i]) begin
        failures++;
        $display("FAIL load_sp sp=%h required %h", sp, vals[i]);
      end
    end
  endtask

  task automatic test_push();
    int d0 = n_dec;
    ack_delay = 3;
    send(OP_PUSH, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (sp_dec !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL push_dec dec=%b mem_req=%b required 1 0",
               sp_dec, mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h01FE ||
        mem_wdata !== 16'hBEEF || sp_dec !== 1'b0) begin
      failures++;
      $display("FAIL push_wr req=%b we=%b addr=%h wd=%h required 1 1 01fe beef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    get_rsp(20);
    checks++;
    if (sp !== 16'h01FE || n_dec - d0 != 1 || mem[16'h01FE] !== 16'hBEEF) begin
      failures++;
      $display("FAIL push_after sp=%h decs=%0d required 01fe 1",
               sp, n_dec - d0);
    end
    ack_delay = 0;
  endtask

  task automatic test_pop();
    ack_delay = 0;
    send(OP_POP, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h01FE) begin
      failures++;
      $display("FAIL pop_rd req=%b we=%b addr=%h required 1 0 01fe",
               mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (sp_inc !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL pop_inc inc=%b mem_req=%b required 1 0",
               sp_inc, mem_req);
    end
    get_rsp(10);
    checks++;
    if (sp !== 16'h0200) begin
      failures++;
      $display("FAIL pop_sp sp=%h required 0200", sp);
    end
  endtask

  task automatic test_errors();
    int a0;
    a0 = activity();
    send(OP_POP, 16'h0000, 16'h0000, 1'b1, 1'b1);
    get_rsp(10);
    checks++;
    if (activity() != a0) begin
      failures++;
      $display("FAIL underflow_quiet events=%0d required 0", activity() - a0);
    end
    send(OP_LOAD, 16'h0100, 16'h0000, 1'b0, 1'b1);
    get_rsp(10);
    a0 = activity();
    send(OP_PUSH, 16'h1234, 16'h0000, 1'b1, 1'b1);
    get_rsp(10);
    checks++;
    if (activity() != a0 || sp !== 16'h0100) begin
      failures++;
      $display("FAIL overflow_quiet events=%0d sp=%h required 0 0100",
               activity() - a0, sp);
    end
    a0 = activity();
    send(OP_LOAD, 16'h0201, 16'h0000, 1'b1, 1'b1);
    get_rsp(10);
    send(OP_LOAD, 16'h00FE, 16'h0000, 1'b1, 1'b1);
    get_rsp(10);
    send(OP_RSVD, 16'h0150, 16'h0000, 1'b1, 1'b1);
    get_rsp(10);
    checks++;
    if (activity() != a0 || sp !== 16'h0100) begin
      failures++;
      $display("FAIL badload_quiet events=%0d sp=%h required 0 0100",
               activity() - a0, sp);
    end
    send(OP_LOAD, 16'h0200, 16'h0000, 1'b0, 1'b1);
    get_rsp(10);
  endtask

  task automatic test_abort();
    int nv = 0, nr = 0;
    ack_delay = 1000;
    send(OP_PUSH, 16'hCAFE, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL abort_wr req=%b we=%b required 1 1", mem_req, mem_we);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0 ||
        {sp_ld, sp_inc, sp_dec} !== 3'b000) begin
      failures++;
      $display("FAIL abort_drop req=%b valid=%b required 0 0",
               mem_req, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    ack_delay = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) nv++;
      if (req_ready !== 1'b1) nr++;
    end
    checks++;
    if (nv != 0 || nr != 0) begin
      failures++;
      $display("FAIL abort_after valid_cycles=%0d notready=%0d required 0 0",
               nv, nr);
    end
  endtask

  task automatic test_backpressure();
    int n = 0, bad = 0;
    send(OP_PUSH, 16'h5A5A, 16'h0000, 1'b0, 1'b1);
    get_rsp(10);
    rsp_ready = 1'b0;
    send(OP_POP, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_data !== 16'h5A5A || rsp_err !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable bad_cycles=%0d required 0", bad);
    end
    rsp_ready = 1'b1;
    get_rsp(5);
    checks++;
    if (req_ready !== 1'b1 || sp !== 16'h0200) begin
      failures++;
      $display("FAIL hold_release ready=%b sp=%h required 1 0200",
               req_ready, sp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] msp = 16'h0200;
    logic [15:0] mm [logic [15:0]];
    logic [15:0] d;
    logic [15:0] lds [3];
    int          sel;
    int          bad = 0;
    lds[0] = 16'h0200;
    lds[1] = 16'h0201;
    lds[2] = 16'h0300;
    send(OP_LOAD, 16'h0200, 16'h0000, 1'b0, 1'b1);
    get_rsp(10);
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        d = 16'($urandom);
        if (msp == 16'h0100) begin
          send(OP_PUSH, d, 16'h0000, 1'b1, 1'b1);
        end else begin
          msp = msp - 16'd2;
          mm[msp] = d;
          send(OP_PUSH, d, 16'h0000, 1'b0, 1'b1);
        end
      end else if (sel < 9) begin
        if (msp == 16'h0200) begin
          send(OP_POP, 16'h0000, 16'h0000, 1'b1, 1'b1);
        end else begin
          send(OP_POP, 16'h0000, mm[msp], 1'b0, 1'b1);
          msp = msp + 16'd2;
        end
      end else begin
        d = lds[$urandom_range(0, 2)];
        if (d == 16'h0200) begin
          msp = d;
          send(OP_LOAD, d, 16'h0000, 1'b0, 1'b1);
        end else begin
          send(OP_LOAD, d, 16'h0000, 1'b1, 1'b1);
        end
      end
      get_rsp(20);
      if (sp !== msp) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_sp mismatched_ops=%0d required 0", bad);
    end
    checks++;
    if (n_multi != 0 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_final multi_strobe=%0d leftover=%0d required 0 0",
               n_multi, sb.size());
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    test_reset();
    test_load();
    test_push();
    test_pop();
    test_errors();
    test_abort();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
